poly_mixer: RTL and testbench



---
 rtl/mypackage.sv | 16 +
 rtl/poly_mixer_mac.sv | 38 +++
 rtl/poly_mixer.sv | 137 +++++++++++++
 tb/tb_poly_mixer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mypackage.sv
// Shared constants and types for the synthesiser datapath.
package mypackage;

    localparam int AMPLITUDE_BITS = 24;
    localparam int MAX_VOICES     = 64;

    typedef logic [$clog2(MAX_VOICES)-1:0] voice_index_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } mix_state_t;

endpackage

// File: rtl/poly_mixer_mac.sv
// Registered top-half multiply followed by an accumulator with synchronous clear.
module poly_mixer_mac #(
    parameter int AMP_W = 24,
    parameter int ACC_W = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             accumulate,
    input  logic [AMP_W-1:0] a,
    input  logic [AMP_W-1:0] b,
    input  logic             gate,
    output logic [ACC_W-1:0] acc
);

    logic [2*AMP_W-1:0] full_product;
    logic [AMP_W-1:0]   product;

    assign full_product = {{AMP_W{1'b0}}, a} * {{AMP_W{1'b0}}, b};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            product <= '0;
            acc     <= '0;
        end else if (clear) begin
            product <= '0;
            acc     <= '0;
        end else begin
            if (load)
                product <= gate ? full_product[2*AMP_W-1:AMP_W] : '0;
            // The accumulator consumes the product registered one cycle earlier.
            if (accumulate)
                acc <= acc + ACC_W'(product);
        end
    end

endmodule

// File: rtl/poly_mixer.sv
// Time-multiplexed voice mixer: one voice product per clock, then saturate or normalise.
//
// state | meaning
// IDLE  | waiting for start; out held
// RUN   | one voice multiplied per cycle, previous product accumulated
// FLUSH | last product added to the accumulator
// DONE  | result registered, out_valid pulsed on the way back to IDLE
module poly_mixer
    import mypackage::*;
#(
    parameter int VOICES         = 8,
    parameter int AMPLITUDE_BITS = mypackage::AMPLITUDE_BITS,
    parameter int NORMALISE      = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [VOICES*AMPLITUDE_BITS-1:0] osc,
    input  logic [VOICES*AMPLITUDE_BITS-1:0] env,
    input  logic [VOICES-1:0]                enable,
    output logic [AMPLITUDE_BITS-1:0]        out,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             clipped,
    output logic                             overrun
);

    localparam int LOG2V = $clog2(VOICES);
    localparam int ACC_W = AMPLITUDE_BITS + LOG2V;
    localparam logic [ACC_W-1:0] SAT_LIMIT = ACC_W'({AMPLITUDE_BITS{1'b1}});

    mix_state_t                state;
    voice_index_t              idx;
    logic [AMPLITUDE_BITS-1:0] osc_sh [VOICES];
    logic [AMPLITUDE_BITS-1:0] env_sh [VOICES];
    logic [VOICES-1:0]         en_sh;

    logic [AMPLITUDE_BITS-1:0] osc_sel;
    logic [AMPLITUDE_BITS-1:0] env_sel;
    logic                      en_sel;
    logic [ACC_W-1:0]          acc;
    logic [ACC_W-1:0]          norm_sum;
    logic                      accept;
    logic                      saturate;

    assign accept   = (state == IDLE) && start;
    assign norm_sum = acc >> LOG2V;
    assign saturate = (NORMALISE == 0) && (acc > SAT_LIMIT);

    always_comb begin
        osc_sel = '0;
        env_sel = '0;
        en_sel  = 1'b0;
        for (int v = 0; v < VOICES; v++) begin
            if (idx == voice_index_t'(v)) begin
                osc_sel = osc_sh[v];
                env_sel = env_sh[v];
                en_sel  = en_sh[v];
            end
        end
    end

    poly_mixer_mac #(
        .AMP_W(AMPLITUDE_BITS),
        .ACC_W(ACC_W)
    ) u_mac (
        .clock     (clock),
        .reset     (reset),
        .clear     (accept),
        .load      (state == RUN),
        .accumulate((state == RUN) || (state == FLUSH)),
        .a         (osc_sel),
        .b         (env_sel),
        .gate      (en_sel),
        .acc       (acc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            en_sh     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            clipped   <= 1'b0;
            overrun   <= 1'b0;
            for (int v = 0; v < VOICES; v++) begin
                osc_sh[v] <= '0;
                env_sh[v] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (start && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int v = 0; v < VOICES; v++) begin
                            osc_sh[v] <= osc[v*AMPLITUDE_BITS +: AMPLITUDE_BITS];
                            env_sh[v] <= env[v*AMPLITUDE_BITS +: AMPLITUDE_BITS];
                        end
                        en_sh <= enable;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (idx == voice_index_t'(VOICES - 1)) begin
                        state <= FLUSH;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                FLUSH: begin
                    state <= DONE;
                end
                DONE: begin
                    if (NORMALISE != 0)
                        out <= norm_sum[AMPLITUDE_BITS-1:0];
                    else if (saturate)
                        out <= '1;
                    else
                        out <= acc[AMPLITUDE_BITS-1:0];
                    clipped   <= saturate;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    idx       <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_mixer.sv
// Scoreboard bench: two 4-voice mixers (saturating and normalising) fed identical stimulus.
module tb_poly_mixer;

    localparam int V = 4;
    localparam int A = 24;
    localparam int LAT = V + 3;

    typedef struct {
        logic [A-1:0] out0;
        logic         clip0;
        logic [A-1:0] out1;
        logic         clip1;
        int           due;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [V*A-1:0] osc   = '0;
    logic [V*A-1:0] env   = '0;
    logic [V-1:0]   enable = '0;

    logic [A-1:0] out0, out1;
    logic         valid0, valid1, busy0, busy1, clip0, clip1, ovr0, ovr1;

    exp_t q[$];
    int   cyc = 0;
    int   last_acc = -100;
    logic exp_ovr = 1'b0;
    int   nchk = 0;
    int   npass = 0;

    poly_mixer #(.VOICES(V), .NORMALISE(0)) u_mix0 (
        .clock(clock), .reset(reset), .start(start), .osc(osc), .env(env),
        .enable(enable), .out(out0), .out_valid(valid0), .busy(busy0),
        .clipped(clip0), .overrun(ovr0)
    );

    poly_mixer #(.VOICES(V), .NORMALISE(1)) u_mix1 (
        .clock(clock), .reset(reset), .start(start), .osc(osc), .env(env),
        .enable(enable), .out(out1), .out_valid(valid1), .busy(busy1),
        .clipped(clip1), .overrun(ovr1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        nchk++;
        if (act === exp_v) npass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    endtask

    // Sum of per-voice top-half products computed with plain wide arithmetic.
    function automatic exp_t model(input logic [V*A-1:0] o, input logic [V*A-1:0] e,
                                   input logic [V-1:0] en, input int due);
        exp_t    r;
        longint  sum = 0;
        longint  ov, ev;
        for (int v = 0; v < V; v++) begin
            if (en[v]) begin
                ov = longint'(o[v*A +: A]);
                ev = longint'(e[v*A +: A]);
                sum += (ov * ev) >> A;
            end
        end
        if (sum > longint'(24'hFFFFFF)) begin
            r.out0  = 24'hFFFFFF;
            r.clip0 = 1'b1;
        end else begin
            r.out0  = sum[A-1:0];
            r.clip0 = 1'b0;
        end
        sum     = sum / V;
        r.out1  = sum[A-1:0];
        r.clip1 = 1'b0;
        r.due   = due;
        return r;
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            chk("busy0", 32'(busy0), 32'((cyc > last_acc) && (cyc < last_acc + LAT)));
            chk("busy1", 32'(busy1), 32'((cyc > last_acc) && (cyc < last_acc + LAT)));
            chk("overrun0", 32'(ovr0), 32'(exp_ovr));
            chk("overrun1", 32'(ovr1), 32'(exp_ovr));
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("valid0", 32'(valid0), 32'd1);
                chk("valid1", 32'(valid1), 32'd1);
                chk("out_sat", 32'(out0), 32'(e.out0));
                chk("clip_sat", 32'(clip0), 32'(e.clip0));
                chk("out_norm", 32'(out1), 32'(e.out1));
                chk("clip_norm", 32'(clip1), 32'(e.clip1));
            end else begin
                chk("no_valid0", 32'(valid0), 32'd0);
                chk("no_valid1", 32'(valid1), 32'd0);
            end
        end
    end

    task automatic scramble();
        for (int v = 0; v < V; v++) begin
            osc[v*A +: A] = A'($urandom);
            env[v*A +: A] = A'($urandom);
        end
        enable = V'($urandom);
    endtask

    task automatic issue(input logic [V*A-1:0] o, input logic [V*A-1:0] e, input logic [V-1:0] en);
        logic rej;
        rej    = 1'b0;
        osc    = o;
        env    = e;
        enable = en;
        start  = 1'b1;
        if (cyc >= last_acc + LAT) begin
            last_acc = cyc;
            q.push_back(model(o, e, en, cyc + LAT));
        end else begin
            rej = 1'b1;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        if (rej) exp_ovr = 1'b1;
        scramble();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_out0", 32'(out0), 32'd0);
        chk("rst_out1", 32'(out1), 32'd0);
        chk("rst_valid", 32'({valid0, valid1}), 32'd0);
        chk("rst_busy", 32'({busy0, busy1}), 32'd0);
        chk("rst_clip", 32'({clip0, clip1}), 32'd0);
        chk("rst_ovr", 32'({ovr0, ovr1}), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs();
        q.delete();
        last_acc = -100;
        exp_ovr  = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [V*A-1:0] fill(input logic [A-1:0] v0, input logic [A-1:0] v1,
                                            input logic [A-1:0] v2, input logic [A-1:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    initial begin
        logic [V*A-1:0] ro, re;
        int waited;

        idle(3);
        check_reset_outputs();
        reset = 1'b0;
        idle(2);

        // single full-scale voice
        issue(fill(24'hFFFFFF, 24'h123456, 24'h654321, 24'hABCDEF),
              fill(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF), 4'b0001);
        idle(10);
        // two half-scale voices fit, three saturate
        issue(fill(24'h800000, 24'h800000, 24'h800000, 24'h0),
              fill(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h0), 4'b0011);
        idle(10);
        issue(fill(24'h800000, 24'h800000, 24'h800000, 24'h0),
              fill(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h0), 4'b0111);
        idle(10);
        // all voices full scale: normalised path stays unclipped
        issue({V{24'hFFFFFF}}, {V{24'hFFFFFF}}, 4'b1111);
        idle(10);
        // everything disabled
        issue({V{24'hFFFFFF}}, {V{24'hFFFFFF}}, 4'b0000);
        idle(10);

        // restart while busy, then start coincident with out_valid
        issue({V{24'h400000}}, {V{24'h300000}}, 4'b1011);
        idle(2);
        issue({V{24'hFFFFFF}}, {V{24'hFFFFFF}}, 4'b1111);
        idle(3);
        issue({V{24'h222222}}, {V{24'hEEEEEE}}, 4'b0110);
        idle(10);
        issue({V{24'h111111}}, {V{24'h999999}}, 4'b1111);
        idle(10);

        // reset in the middle of RUN
        issue({V{24'hFFFFFF}}, {V{24'hFFFFFF}}, 4'b1111);
        idle(2);
        pulse_reset();
        idle(3);
        issue(fill(24'hFFFFFF, 24'h0, 24'h0, 24'h0), fill(24'hFFFFFF, 24'h0, 24'h0, 24'h0), 4'b0001);
        idle(10);

        for (int i = 0; i < 40; i++) begin
            for (int v = 0; v < V; v++) begin
                ro[v*A +: A] = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : A'($urandom);
                re[v*A +: A] = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : A'($urandom);
            end
            issue(ro, re, V'($urandom));
            idle($urandom_range(0, 9));
        end

        waited = 0;
        while (q.size() > 0 && waited < 50) begin
            idle(1);
            waited++;
        end
        if (q.size() > 0) begin
            nchk++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end
        idle(2);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
